// File: rtl/vector_sequencer.sv
// Stimulus/response vector engine: replays stored vector pairs into a DUT
// and scores the DUT response against the expected values after LAT cycles.
module vector_sequencer #(
    parameter int SW    = 2,
    parameter int RW    = 1,
    parameter int DEPTH = 4,
    parameter int LAT   = 0,
    parameter int CW    = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [SW-1:0] load_stim,
    input  logic [RW-1:0] load_exp,
    input  logic          start,
    input  logic          loop_mode,
    input  logic          stop,
    output logic [SW-1:0] stim,
    output logic          stim_valid,
    input  logic [RW-1:0] resp,
    output logic          mismatch,
    output logic [AW-1:0] vec_index,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] pass_count,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [SW-1:0] mem_stim [DEPTH];
    logic [RW-1:0] mem_exp  [DEPTH];

    state_t        state_q;
    logic [SW-1:0] stim_q;
    logic [RW-1:0] exp_q;
    logic          stim_valid_q;
    logic [AW-1:0] idx_q;
    logic          loop_q;
    logic          mm_q;
    logic [CW-1:0] err_q;
    logic [CW-1:0] pcnt_q;
    logic          done_q;

    logic          busy_w;
    logic          last;
    logic [AW-1:0] idx_nxt;
    logic [SW-1:0] first_stim;
    logic [RW-1:0] first_exp;
    logic          cmp_v;
    logic [RW-1:0] cmp_e;
    logic          pipe_busy;
    logic          mm_d;

    assign busy_w  = (state_q == RUN) || (state_q == DRAIN);
    assign last    = (idx_q == AW'(DEPTH - 1));
    assign idx_nxt = last ? '0 : idx_q + 1'b1;

    // A write landing with start must already be visible to vector 0.
    assign first_stim = (load_en && load_addr == '0) ? load_stim : mem_stim[0];
    assign first_exp  = (load_en && load_addr == '0) ? load_exp  : mem_exp[0];

    always_ff @(posedge clk) begin
        if (load_en && !busy_w) begin
            mem_stim[load_addr] <= load_stim;
            mem_exp[load_addr]  <= load_exp;
        end
    end

    generate
        if (LAT == 0) begin : g_comb
            assign cmp_v     = stim_valid_q;
            assign cmp_e     = exp_q;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0] pv_q;
            logic [RW-1:0]  pe_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= stim_valid_q;
                    for (int i = 1; i < LAT; i++) begin
                        pv_q[i] <= pv_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pe_q[0] <= exp_q;
                for (int i = 1; i < LAT; i++) begin
                    pe_q[i] <= pe_q[i-1];
                end
            end

            // Pipe counts as empty once only the stage under compare remains.
            always_comb begin
                pipe_busy = 1'b0;
                for (int i = 0; i < LAT - 1; i++) begin
                    pipe_busy = pipe_busy | pv_q[i];
                end
            end

            assign cmp_v = pv_q[LAT-1];
            assign cmp_e = pe_q[LAT-1];
        end
    endgenerate

    assign mm_d = cmp_v && (resp != cmp_e);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            exp_q        <= '0;
            stim_valid_q <= 1'b0;
            idx_q        <= '0;
            loop_q       <= 1'b0;
            mm_q         <= 1'b0;
            err_q        <= '0;
            pcnt_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            mm_q <= mm_d;
            if (mm_d && err_q != '1) begin
                err_q <= err_q + 1'b1;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        stim_valid_q <= 1'b1;
                        idx_q        <= '0;
                        stim_q       <= first_stim;
                        exp_q        <= first_exp;
                        loop_q       <= loop_mode;
                        err_q        <= '0;
                        pcnt_q       <= '0;
                        done_q       <= 1'b0;
                    end
                end
                RUN: begin
                    if (last && pcnt_q != '1) begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                    idx_q <= idx_nxt;
                    if ((last && !loop_q) || stop) begin
                        stim_valid_q <= 1'b0;
                        state_q      <= (LAT == 0) ? DONE : DRAIN;
                        done_q       <= (LAT == 0);
                    end else begin
                        stim_q <= mem_stim[idx_nxt];
                        exp_q  <= mem_exp[idx_nxt];
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim       = stim_q;
    assign stim_valid = stim_valid_q;
    assign mismatch   = mm_q;
    assign vec_index  = idx_q;
    assign err_count  = err_q;
    assign pass_count = pcnt_q;
    assign busy       = busy_w;
    assign done       = done_q;
    assign pass       = done_q && (err_q == '0) && (pcnt_q != '0);

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench: two sequencers (LAT=0 and LAT=2) share controls; each drives a
// modelled DUT; results are scored against a vector-list reference model.
module tb_vector_sequencer;

    localparam int SW = 2;
    localparam int RW = 1;
    localparam int D  = 4;
    localparam int CW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [SW-1:0] load_stim = '0;
    logic [RW-1:0] load_exp = '0;
    logic          start = 1'b0;
    logic          loop_mode = 1'b0;
    logic          stop = 1'b0;

    logic [SW-1:0] stim_a, stim_b;
    logic          sv_a, sv_b;
    logic [RW-1:0] resp_a, resp_b;
    logic          mm_a, mm_b;
    logic [AW-1:0] idx_a, idx_b;
    logic [CW-1:0] err_a, err_b, pc_a, pc_b;
    logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;

    int mode = 0;
    int dly_b = 2;
    int checks = 0;
    int failures = 0;

    logic [SW-1:0] m_stim [D];
    logic          m_exp  [D];

    always #5 clk = ~clk;

    function automatic logic fdut(input int m, input logic [1:0] s);
        return (m == 0) ? ~(s[1] & s[0]) : (s[1] & s[0]);
    endfunction

    assign resp_a = fdut(mode, stim_a);

    logic r1, r2, r3;
    always @(posedge clk) begin
        r1 <= fdut(mode, stim_b);
        r2 <= r1;
        r3 <= r2;
    end
    assign resp_b = (dly_b == 1) ? r1 : (dly_b == 2) ? r2 : r3;

    vector_sequencer #(.SW(SW), .RW(RW), .DEPTH(D), .LAT(0), .CW(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .start(start),
        .loop_mode(loop_mode), .stop(stop), .stim(stim_a), .stim_valid(sv_a),
        .resp(resp_a), .mismatch(mm_a), .vec_index(idx_a), .err_count(err_a),
        .pass_count(pc_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    vector_sequencer #(.SW(SW), .RW(RW), .DEPTH(D), .LAT(2), .CW(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .start(start),
        .loop_mode(loop_mode), .stop(stop), .stim(stim_b), .stim_valid(sv_b),
        .resp(resp_b), .mismatch(mm_b), .vec_index(idx_b), .err_count(err_b),
        .pass_count(pc_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wr_vec(input int a, input logic [1:0] s, input logic e);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a[AW-1:0];
        load_stim = s;
        load_exp  = e;
        m_stim[a] = s;
        m_exp[a]  = e;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run(input bit lp, input int stop_at, input bit ss,
                       input bit ld, input logic [1:0] ls, input logic le,
                       input bit bld, input bit aligned);
        int k = 0;
        int mma = 0;
        int mmb = 0;
        int dra = 0;
        int drb = 0;
        int cyc = 0;
        int issued;
        int ea = 0;
        bit fin = 0;
        @(negedge clk);
        start = 1'b1;
        loop_mode = lp;
        stop = ss;
        if (ld) begin
            load_en = 1'b1; load_addr = '0; load_stim = ls; load_exp = le;
            m_stim[0] = ls; m_exp[0] = le;
        end
        @(negedge clk);
        start = 1'b0;
        if (lp) issued = stop_at;
        else if (stop_at >= 1 && stop_at < D) issued = stop_at;
        else issued = D;
        while (!fin) begin
            stop = 1'b0;
            load_en = 1'b0;
            if (sv_a) begin
                chk("stim", stim_a, m_stim[k % D]);
                chk("vec_index", idx_a, k % D);
                k++;
                if (k == stop_at) stop = 1'b1;
                if (bld && k == 2) begin
                    load_en = 1'b1; load_addr = '0;
                    load_stim = ~m_stim[0]; load_exp = ~m_exp[0];
                end
            end
            if (mm_a) mma++;
            if (mm_b) mmb++;
            if (busy_a && !sv_a) dra++;
            if (busy_b && !sv_b) drb++;
            if (done_a && done_b) fin = 1;
            else begin
                cyc++;
                if (cyc > 200) begin
                    chk("timeout", 0, 1);
                    fin = 1;
                end else @(negedge clk);
            end
        end
        stop = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < issued; i++)
            if (fdut(mode, m_stim[i % D]) !== m_exp[i % D]) ea++;
        chk("issued", k, issued);
        chk("err_a", err_a, ea);
        chk("mm_pulses_a", mma, ea);
        chk("pass_count_a", pc_a, issued / D);
        chk("pass_a", pass_a, (ea == 0) && (issued >= D));
        chk("drain_a", dra, 0);
        chk("drain_b", drb, 2);
        chk("pass_count_b", pc_b, issued / D);
        if (aligned) begin
            chk("err_b", err_b, ea);
            chk("mm_pulses_b", mmb, ea);
            chk("pass_b", pass_b, (ea == 0) && (issued >= D));
        end else begin
            chk("err_b_misalign", err_b != 0, 1);
        end
    endtask

    task automatic reset_mid_run();
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        loop_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!(sv_a && idx_a == 2) && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("reach_idx2", idx_a, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_stim", stim_a, 0);
        chk("rst_valid", sv_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_pc", pc_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] s;
        bit lp;
        int sa;
        @(negedge clk);
        @(negedge clk);
        chk("reset_stim", stim_a, 0);
        chk("reset_valid", sv_a, 0);
        chk("reset_idx", idx_a, 0);
        chk("reset_mm", mm_a, 0);
        chk("reset_err", err_a, 0);
        chk("reset_pc", pc_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_pass", pass_a, 0);
        rst_n = 1'b1;

        for (int a = 0; a < D; a++) begin
            s = a[1:0];
            wr_vec(a, s, (a == 3) ? 1'b0 : 1'b1);
        end
        mode = 0; dly_b = 2;
        run(0, 0, 0, 0, 2'b00, 1'b0, 0, 1);
        mode = 1;
        run(0, 0, 0, 0, 2'b00, 1'b0, 0, 1);
        mode = 0; dly_b = 1;
        run(0, 0, 0, 0, 2'b00, 1'b0, 0, 0);
        dly_b = 2;
        run(1, 10, 0, 0, 2'b00, 1'b0, 0, 1);
        run(0, 4, 0, 0, 2'b00, 1'b0, 0, 1);
        run(0, 2, 0, 0, 2'b00, 1'b0, 0, 1);
        run(0, 0, 1, 0, 2'b00, 1'b0, 0, 1);
        run(0, 0, 0, 0, 2'b00, 1'b0, 1, 1);
        run(0, 0, 0, 0, 2'b00, 1'b0, 0, 1);
        run(0, 0, 0, 1, 2'b00, 1'b0, 0, 1);
        wr_vec(0, 2'b00, 1'b1);
        reset_mid_run();
        run(0, 0, 0, 0, 2'b00, 1'b0, 0, 1);

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < D; a++) begin
                s = 2'($urandom);
                wr_vec(a, s, fdut(0, s) ^ ($urandom_range(0, 3) == 0));
            end
            mode = $urandom_range(0, 1);
            lp = 1'($urandom_range(0, 1));
            sa = lp ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 5));
            run(lp, sa, 0, 0, 2'b00, 1'b0, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
